score_keeper: RTL

Sequential producer of the 32-bit binary score bus consumed by the on-screen score renderer. It runs the game's scoring state machine, adds distance points per frame and bonus points per bean collected, saturates at the 4-digit display limit, and tracks a session high score. Sits in the game-logic clock domain between the collision/frame-timing logic and the VGA overlay.

---
 rtl/score_pkg.sv | 20 ++
 rtl/score_tick_div.sv | 43 ++++
 rtl/score_keeper.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared types and default constants for the score keeper.
// Contents: state_t (IDLE/RUN/OVER), the default scoring constants, and
// cnt_width(), which sizes a counter that must hold 0..n-1 (at least 1 bit).
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_MAX_SCORE        = 9999;
  localparam int unsigned DEFAULT_BEAN_POINTS      = 10;
  localparam int unsigned DEFAULT_FRAMES_PER_POINT = 6;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/score_tick_div.sv
// Frame divider: counts frame_tick pulses while enabled and raises `point`
// combinationally on the FRAMES_PER_POINT-th tick, wrapping back to 0 on that
// same edge.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   clear       - synchronous clear of the count (new run)
//   enable      - count only while set (RUN state, no game_over)
//   frame_tick  - one pulse per VGA frame
//   point       - one-cycle pulse, same cycle as the wrapping tick
module score_tick_div
  import score_pkg::*;
#(
  parameter int unsigned FRAMES_PER_POINT = DEFAULT_FRAMES_PER_POINT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic frame_tick,
  output logic point
);

  localparam int unsigned CW = cnt_width(FRAMES_PER_POINT);
  localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_POINT - 1);

  logic [CW-1:0] count_q;
  logic          tick_en;

  assign tick_en = enable & frame_tick;
  assign point   = tick_en & (count_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (tick_en) begin
      if (count_q == LAST) count_q <= '0;
      else                 count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Score keeper: runs the game scoring FSM, accumulates distance and bean
// points with saturation at MAX_SCORE, and tracks the session high score.
// Optional feature macro: SCORE_HIGH_SCORE_EN (high-score register, compare
// and new_high). Without it high_score and new_high are tied to 0.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   start       - pulse: begin a new run (IDLE/OVER only)
//   frame_tick  - pulse per VGA frame
//   bean_hit    - pulse per bean collected
//   game_over   - pulse: collision ends the run (RUN only)
//   score       - current score (registered)
//   high_score  - best finished-run score this session (registered)
//   new_high    - last finished run beat the previous high score
//   running     - state is RUN
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | after reset; score held at 0, waiting for start
// RUN   | run in progress; distance and bean points accumulate
// OVER  | run ended; score frozen for display, waiting for start
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned FRAMES_PER_POINT = DEFAULT_FRAMES_PER_POINT,
  parameter int unsigned BEAN_POINTS      = DEFAULT_BEAN_POINTS,
  parameter int unsigned MAX_SCORE        = DEFAULT_MAX_SCORE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        frame_tick,
  input  logic        bean_hit,
  input  logic        game_over,
  output logic [31:0] score,
  output logic [31:0] high_score,
  output logic        new_high,
  output logic        running
);

  localparam logic [32:0] MAX_W  = 33'(MAX_SCORE);
  localparam logic [32:0] BEAN_W = 33'(BEAN_POINTS);

  state_t      state_q, state_d;
  logic [31:0] score_q, score_d;
  logic        start_run;
  logic        end_run;
  logic        div_en;
  logic        point;
  logic [32:0] inc;
  logic [32:0] sum;
  logic [31:0] sat_sum;

  // Events are only counted in RUN, and game_over discards same-cycle events.
  assign div_en = (state_q == RUN) & ~game_over;

  score_tick_div #(
    .FRAMES_PER_POINT(FRAMES_PER_POINT)
  ) u_tick_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_run),
    .enable    (div_en),
    .frame_tick(frame_tick),
    .point     (point)
  );

  // 33-bit sum so the ceiling compare cannot be fooled by a 32-bit wrap.
  always_comb begin
    inc = 33'd0;
    if (point)    inc = inc + 33'd1;
    if (bean_hit) inc = inc + BEAN_W;
    sum     = {1'b0, score_q} + inc;
    sat_sum = (sum > MAX_W) ? MAX_W[31:0] : sum[31:0];
  end

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    start_run = 1'b0;
    end_run   = 1'b0;
    case (state_q)
      IDLE: begin
        score_d = '0;
        if (start) begin
          state_d   = RUN;
          start_run = 1'b1;
        end
      end
      RUN: begin
        if (game_over) begin
          state_d = OVER;
          end_run = 1'b1;
        end else begin
          score_d = sat_sum;
        end
      end
      OVER: begin
        if (start) begin
          state_d   = RUN;
          score_d   = '0;
          start_run = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        score_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
    end
  end

  assign score   = score_q;
  assign running = (state_q == RUN);

`ifdef SCORE_HIGH_SCORE_EN
  logic [31:0] high_q;
  logic        new_high_q;

  // Compare uses the frozen final score; equal does not count as a new high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      high_q     <= '0;
      new_high_q <= 1'b0;
    end else if (end_run) begin
      if (score_q > high_q) begin
        high_q     <= score_q;
        new_high_q <= 1'b1;
      end else begin
        new_high_q <= 1'b0;
      end
    end else if (start_run) begin
      new_high_q <= 1'b0;
    end
  end

  assign high_score = high_q;
  assign new_high   = new_high_q;
`else
  assign high_score = '0;
  assign new_high   = 1'b0;
`endif

endmodule
